// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multicycle sequencer and the MIPS datapath
interface multicycle_control_if;
    logic [5:0] OP;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCondEQ;
    logic       PCWriteCondNE;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       InstrDone;
    logic       IllegalOp;
    logic [3:0] State;

    // Sequencer side: consumes opcode and memory ready, drives every enable and select.
    modport master (
        input  OP, MemReady,
        output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, InstrDone, IllegalOp, State
    );

    // Datapath side: supplies opcode and memory ready, obeys the controls.
    modport slave (
        output OP, MemReady,
        input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, InstrDone, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control sequencer (fetch/decode/execute/memory/writeback)
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t state_q;
    state_t state_d;

    logic       pc_write;
    logic       pc_write_cond_eq;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;

    // ALU function for the immediate-ALU group; only reached for those four opcodes.
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_OR;
            OP_ANDI: return ALU_AND;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

    // First execution state for each supported opcode; FETCH doubles as "unsupported".
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                        return S_R_EXEC;
            OP_LW, OP_SW:                    return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                  return S_BRANCH;
            OP_J:                            return S_JUMP;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return S_I_EXEC;
            default:                         return S_FETCH;
        endcase
    endfunction

    // State register; reset returns to FETCH at once, aborting any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; memory states hold until MemReady, unused codes recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = dispatch(bus.OP);
            S_MEM_ADDR:  state_d = (bus.OP == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = bus.MemReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = bus.MemReady ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the current state; write strobes are killed while reset is low.
    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        iord             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_dst          = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = SRCB_REG;
        alu_op           = ALU_ADD;
        pc_source        = PCSRC_ALU;
        instr_done       = 1'b0;
        illegal_op       = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed in parallel with the read; IR and PC load when the read lands.
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut while the register file is read.
                alu_src_b  = SRCB_IMMSH;
                illegal_op = (dispatch(bus.OP) == S_FETCH);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = bus.MemReady;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                // Compare A-B; the target computed in DECODE sits in ALUOut.
                alu_src_a        = 1'b1;
                alu_op           = ALU_SUB;
                pc_source        = PCSRC_ALUOUT;
                pc_write_cond_eq = (bus.OP == OP_BEQ);
                pc_write_cond_ne = (bus.OP == OP_BNE);
                instr_done       = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = imm_alu_op(bus.OP);
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase

        if (!reset) begin
            pc_write         = 1'b0;
            pc_write_cond_eq = 1'b0;
            pc_write_cond_ne = 1'b0;
            ir_write         = 1'b0;
            reg_write        = 1'b0;
            mem_write        = 1'b0;
            instr_done       = 1'b0;
            illegal_op       = 1'b0;
        end
    end

    assign bus.PCWrite       = pc_write;
    assign bus.PCWriteCondEQ = pc_write_cond_eq;
    assign bus.PCWriteCondNE = pc_write_cond_ne;
    assign bus.IorD          = iord;
    assign bus.MemRead       = mem_read;
    assign bus.MemWrite      = mem_write;
    assign bus.IRWrite       = ir_write;
    assign bus.MemtoReg      = mem_to_reg;
    assign bus.RegDst        = reg_dst;
    assign bus.RegWrite      = reg_write;
    assign bus.ALUSrcA       = alu_src_a;
    assign bus.ALUSrcB       = alu_src_b;
    assign bus.ALUOp         = alu_op;
    assign bus.PCSource      = pc_source;
    assign bus.InstrDone     = instr_done;
    assign bus.IllegalOp     = illegal_op;
    assign bus.State         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, eq, ne, iord, mr, mw, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcs;
        logic       done, ill;
    } ctl_t;

    typedef enum {K_R, K_LW, K_SW, K_BR, K_J, K_I, K_BAD} kind_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus_if();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int   checks = 0;
    int   passed = 0;
    ctl_t expq[$];
    logic [3:0] trace[$];
    ctl_t seen[16];
    int   done_cnt = 0;
    int   ill_cnt  = 0;

    function automatic ctl_t observe();
        ctl_t o;
        o.st    = bus_if.State;
        o.pcw   = bus_if.PCWrite;
        o.eq    = bus_if.PCWriteCondEQ;
        o.ne    = bus_if.PCWriteCondNE;
        o.iord  = bus_if.IorD;
        o.mr    = bus_if.MemRead;
        o.mw    = bus_if.MemWrite;
        o.irw   = bus_if.IRWrite;
        o.m2r   = bus_if.MemtoReg;
        o.rdst  = bus_if.RegDst;
        o.rw    = bus_if.RegWrite;
        o.srca  = bus_if.ALUSrcA;
        o.srcb  = bus_if.ALUSrcB;
        o.aluop = bus_if.ALUOp;
        o.pcs   = bus_if.PCSource;
        o.done  = bus_if.InstrDone;
        o.ill   = bus_if.IllegalOp;
        return o;
    endfunction

    function automatic ctl_t blank(input logic [3:0] s);
        ctl_t e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic kind_t classify(input logic [5:0] op);
        if (op == 6'h00) return K_R;
        if (op == 6'h23) return K_LW;
        if (op == 6'h2B) return K_SW;
        if (op == 6'h04 || op == 6'h05) return K_BR;
        if (op == 6'h02) return K_J;
        if (op == 6'h08 || op == 6'h0D || op == 6'h0C || op == 6'h0F) return K_I;
        return K_BAD;
    endfunction

    function automatic logic [31:0] trace_word();
        logic [31:0] w = '0;
        foreach (trace[i]) w = (w << 4) | 32'(trace[i]);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Every cycle with an expectation queued, the whole control word is compared.
    initial begin
        ctl_t e, o;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                o = observe();
                checks++;
                if (o === e) passed++;
                else $display("FAIL cycle_ctl state=%0d: got %h expected %h", o.st, o, e);
                trace.push_back(o.st);
                seen[o.st] = o;
                if (o.done) done_cnt++;
                if (o.ill) ill_cnt++;
            end
        end
    end

    // Applies this cycle's inputs, records what the cycle must look like, waits one clock.
    task automatic cyc(input logic [5:0] op, input logic mr, input ctl_t e);
        bus_if.OP       = op;
        bus_if.MemReady = mr;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction: fw wait cycles in instruction fetch, mw wait cycles in the data access.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
        kind_t k;
        ctl_t  e;
        logic  rdy;
        k = classify(op);
        trace.delete();
        done_cnt = 0;
        ill_cnt  = 0;
        foreach (seen[i]) seen[i] = '0;

        // Instruction fetch from PC with PC+4 computed alongside; IR and PC load only on ready.
        for (int i = 0; i <= fw; i++) begin
            rdy = (i == fw);
            e = blank(4'd0); e.mr = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy;
            cyc(6'h2A, rdy, e);
        end
        // Register read and branch-target precompute (PC + imm<<2).
        e = blank(4'd1); e.srcb = 2'b11; e.ill = (k == K_BAD);
        cyc(op, 1'($urandom_range(0, 1)), e);

        case (k)
            K_R: begin
                e = blank(4'd6); e.srca = 1; e.aluop = 3'd2;
                cyc(op, 1'($urandom_range(0, 1)), e);
                e = blank(4'd7); e.rw = 1; e.rdst = 1; e.done = 1;
                cyc(op, 1'($urandom_range(0, 1)), e);
            end
            K_LW, K_SW: begin
                e = blank(4'd2); e.srca = 1; e.srcb = 2'b10;
                cyc(op, 1'($urandom_range(0, 1)), e);
                if (abort) begin
                    bus_if.OP = op;
                    bus_if.MemReady = 1'b1;
                    #1;
                    check("abort_memwrite_before", 32'(bus_if.MemWrite), 32'd1);
                    check("abort_state_before", 32'(bus_if.State), 32'd5);
                    reset = 1'b0;
                    #1;
                    check("abort_memwrite_drop", 32'(bus_if.MemWrite), 32'd0);
                    check("abort_state_fetch", 32'(bus_if.State), 32'd0);
                    check("abort_no_done", 32'(bus_if.InstrDone), 32'd0);
                    @(posedge clk);
                    #1;
                    check("abort_state_held", 32'(bus_if.State), 32'd0);
                    check("abort_regwrite_off", 32'(bus_if.RegWrite), 32'd0);
                    reset = 1'b1;
                    check("abort_done_count", 32'(done_cnt), 32'd0);
                    return;
                end
                for (int i = 0; i <= mw; i++) begin
                    rdy = (i == mw);
                    if (k == K_LW) begin
                        e = blank(4'd3); e.mr = 1; e.iord = 1;
                    end else begin
                        e = blank(4'd5); e.mw = 1; e.iord = 1; e.done = rdy;
                    end
                    cyc(op, rdy, e);
                end
                if (k == K_LW) begin
                    e = blank(4'd4); e.rw = 1; e.m2r = 1; e.done = 1;
                    cyc(op, 1'($urandom_range(0, 1)), e);
                end
            end
            K_BR: begin
                e = blank(4'd8); e.srca = 1; e.aluop = 3'd1; e.pcs = 2'b01; e.done = 1;
                e.eq = (op == 6'h04); e.ne = (op == 6'h05);
                cyc(op, 1'($urandom_range(0, 1)), e);
            end
            K_J: begin
                e = blank(4'd9); e.pcw = 1; e.pcs = 2'b10; e.done = 1;
                cyc(op, 1'($urandom_range(0, 1)), e);
            end
            K_I: begin
                e = blank(4'd10); e.srca = 1; e.srcb = 2'b10;
                e.aluop = (op == 6'h0D) ? 3'd3 : (op == 6'h0C) ? 3'd4 : (op == 6'h0F) ? 3'd5 : 3'd0;
                cyc(op, 1'($urandom_range(0, 1)), e);
                e = blank(4'd11); e.rw = 1; e.done = 1;
                cyc(op, 1'($urandom_range(0, 1)), e);
            end
            default: begin
            end
        endcase
        check("instr_done_pulses", 32'(done_cnt), (k == K_BAD) ? 32'd0 : 32'd1);
        check("illegal_pulses", 32'(ill_cnt), (k == K_BAD) ? 32'd1 : 32'd0);
        check("back_to_fetch", 32'(bus_if.State), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_if.OP = 6'h00;
        bus_if.MemReady = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_state", 32'(bus_if.State), 32'd0);
        check("reset_memread", 32'(bus_if.MemRead), 32'd1);
        check("reset_pcwrite", 32'(bus_if.PCWrite), 32'd0);
        check("reset_irwrite", 32'(bus_if.IRWrite), 32'd0);
        check("reset_srcb", 32'(bus_if.ALUSrcB), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_state_held", 32'(bus_if.State), 32'd0);
        reset = 1'b1;

        run_instr(6'h00, 0, 0, 0);
        check("rtype_trace", trace_word(), 32'h0167);
        check("rtype_len", 32'(trace.size()), 32'd4);
        check("rtype_aluop", 32'(seen[6].aluop), 32'd2);
        check("rtype_wb", {30'd0, seen[7].rw, seen[7].rdst}, 32'd3);

        run_instr(6'h23, 0, 2, 0);
        check("lw_wait_trace", trace_word(), 32'h0123334);
        check("lw_wait_len", 32'(trace.size()), 32'd7);
        check("lw_memtoreg", 32'(seen[4].m2r), 32'd1);

        run_instr(6'h23, 1, 0, 0);
        check("lw_fetchwait_len", 32'(trace.size()), 32'd6);

        run_instr(6'h2B, 1, 1, 0);
        check("sw_len", 32'(trace.size()), 32'd6);

        run_instr(6'h04, 0, 0, 0);
        check("beq_trace", trace_word(), 32'h018);
        check("beq_conds", {30'd0, seen[8].eq, seen[8].ne}, 32'd2);
        check("beq_aluop", 32'(seen[8].aluop), 32'd1);
        check("beq_pcsource", 32'(seen[8].pcs), 32'd1);

        run_instr(6'h05, 0, 0, 0);
        check("bne_conds", {30'd0, seen[8].eq, seen[8].ne}, 32'd1);

        run_instr(6'h02, 0, 0, 0);
        check("j_trace", trace_word(), 32'h019);
        check("j_pcwrite", 32'(seen[9].pcw), 32'd1);
        check("j_pcsource", 32'(seen[9].pcs), 32'd2);

        run_instr(6'h08, 0, 0, 0);
        check("addi_len", 32'(trace.size()), 32'd4);
        run_instr(6'h0D, 0, 0, 0);
        check("ori_aluop", 32'(seen[10].aluop), 32'd3);
        run_instr(6'h0C, 0, 0, 0);
        check("andi_aluop", 32'(seen[10].aluop), 32'd4);
        run_instr(6'h0F, 0, 0, 0);
        check("lui_aluop", 32'(seen[10].aluop), 32'd5);

        run_instr(6'h3F, 0, 0, 0);
        check("illegal_trace", trace_word(), 32'h01);
        check("illegal_flag", 32'(seen[1].ill), 32'd1);
        run_instr(6'h01, 0, 0, 0);
        check("illegal2_len", 32'(trace.size()), 32'd2);

        run_instr(6'h2B, 0, 0, 1);

        run_instr(6'h00, 0, 0, 0);
        check("after_abort_trace", trace_word(), 32'h0167);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle `Control` decode with a state machine that steps one shared ALU, one unified memory port and the register file through fetch, decode, execute, memory and writeback. Each instruction takes 3–5 states, plus wait states while memory is not ready. It drives the datapath enables and mux selects, and consumes the opcode held in the instruction register.

## Interface
- No parameters.
- `clk  input  1`  system clock, rising edge.
- `reset  input  1`  asynchronous, active-low reset.
- `OP  input  6`  opcode, taken from instruction register bits [31:26].
- `MemReady  input  1`  memory has completed the current access; sampled in FETCH, MEM_READ and MEM_WRITE.
- `PCWrite  output  1`  unconditional PC load.
- `PCWriteCondEQ  output  1`  PC load if ALU Zero.
- `PCWriteCondNE  output  1`  PC load if not ALU Zero.
- `IorD  output  1`  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead  output  1`  memory read strobe.
- `MemWrite  output  1`  memory write strobe.
- `IRWrite  output  1`  instruction register load.
- `MemtoReg  output  1`  write-data select: 0 = ALUOut, 1 = MDR.
- `RegDst  output  1`  write-register select: 0 = rt, 1 = rd.
- `RegWrite  output  1`  register file write.
- `ALUSrcA  output  1`  ALU A select: 0 = PC, 1 = A register.
- `ALUSrcB  output  2`  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ALUOp  output  3`  000 add, 001 sub, 010 R-type (funct decides), 011 or, 100 and, 101 lui.
- `PCSource  output  2`  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `InstrDone  output  1`  one-cycle pulse in the final state of each instruction.
- `IllegalOp  output  1`  one-cycle pulse when DECODE sees an unsupported opcode.
- `State  output  4`  current state encoding, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11. Codes 12–15 are unused and go to FETCH.
- Outputs are decoded from State. Any strobe not listed below is 0, and any select not listed is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite and PCWrite equal MemReady. The next state is DECODE if MemReady, otherwise FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). The next state depends on OP:
  - 0x00 → R_EXEC
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 or 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x08, 0x0D, 0x0C or 0x0F → I_EXEC
  - any other opcode → FETCH with IllegalOp=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. The next state is MEM_READ for 0x23 and MEM_WRITE for 0x2B.
- MEM_READ: MemRead=1, IorD=1. Holds until MemReady, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until MemReady, then goes to FETCH. InstrDone equals MemReady.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Then R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, InstrDone=1. PCWriteCondEQ is 1 for OP 0x04, and PCWriteCondNE is 1 for OP 0x05. Then FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Then FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp by opcode: 0x08 → 000, 0x0D → 011, 0x0C → 100, 0x0F → 101. Then I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1. Then FETCH.
- OP is sampled only in DECODE, MEM_ADDR, BRANCH and I_EXEC. The instruction register holds OP stable from the end of FETCH onward.

## Timing
- Reset low: State becomes FETCH immediately (asynchronous). While reset is low, PCWrite, PCWriteCondEQ, PCWriteCondNE, IRWrite, RegWrite, MemWrite, InstrDone and IllegalOp are forced to 0 combinationally. The FETCH select values still appear.
- Reset asserted mid-instruction aborts that instruction. No partial writeback occurs after reset is asserted.
- First rising edge after reset release: the FETCH advance happens if MemReady=1.
- Latency with MemReady held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - I-type ALU: 4 cycles
  - beq/bne: 3 cycles
  - j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle MemReady is 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. During a stall the strobes stay asserted and the memory address stays stable.
- MemReady is ignored in all other states.
- IllegalOp and InstrDone are never high in the same cycle. Each instruction produces exactly one InstrDone pulse; an illegal opcode produces none.

## Test plan
- Reset: hold reset=0 with MemReady=1 → State=0, MemRead=1, PCWrite=0, IRWrite=0. Release reset → State=1 after one edge.
- R-type: OP=0x00, MemReady=1 → State sequence 0,1,6,7,0. ALUOp=010 in R_EXEC. RegWrite=1 with RegDst=1 in R_WB. InstrDone is high for one cycle.
- lw with wait: OP=0x23, MemReady=0 for 2 cycles in MEM_READ → sequence 0,1,2,3,3,3,4,0. IorD=1 throughout MEM_READ. MemtoReg=1 in MEM_WB. Total 7 cycles.
- Branches: OP=0x04 → PCWriteCondEQ=1, PCWriteCondNE=0, ALUOp=001, PCSource=01 in BRANCH. OP=0x05 → PCWriteCondNE=1 instead.
- I-type/jump/illegal:
  - OP=0x0D gives ALUOp=011 in I_EXEC; OP=0x0F gives ALUOp=101.
  - OP=0x02 gives PCWrite=1 and PCSource=10 in JUMP.
  - OP=0x3F gives IllegalOp=1 in DECODE, then State=0.
- Mid-instruction reset: assert reset in MEM_WRITE with MemReady=1 → MemWrite drops immediately, State=0, no InstrDone pulse.
